// File: rtl/parking_pkg.sv
// Shared constants, state encoding and add-amount helpers for the parking meter.
package parking_pkg;

    localparam int CW            = 12;
    localparam int MAX_SEC_DEF   = 3599;
    localparam int GRACE_SEC_DEF = 10;
    localparam int ADD0_DEF      = 60;
    localparam int ADD1_DEF      = 120;
    localparam int ADD2_DEF      = 300;
    localparam int ADD3_DEF      = 600;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRACE   = 2'd1,
        ST_PAID    = 2'd2,
        ST_EXPIRED = 2'd3
    } meter_state_e;

endpackage

// File: rtl/credit_alu.sv
// Combinational saturating credit update: highest-index add wins, optional
// one-second decrement, result clamped to [0, MAX_SEC].
module credit_alu
    import parking_pkg::*;
#(
    parameter int MAX_SEC = MAX_SEC_DEF,
    parameter int ADD0    = ADD0_DEF,
    parameter int ADD1    = ADD1_DEF,
    parameter int ADD2    = ADD2_DEF,
    parameter int ADD3    = ADD3_DEF
) (
    input  logic [CW-1:0] credit,
    input  logic          dec,
    input  logic [3:0]    add_req,
    output logic          add_hit,
    output logic [CW-1:0] result
);

    logic [CW+1:0] amount;
    logic [CW+1:0] sum;
    logic [CW+1:0] diff;

    always_comb begin
        amount = '0;
        if (add_req[3])      amount = (CW+2)'(ADD3);
        else if (add_req[2]) amount = (CW+2)'(ADD2);
        else if (add_req[1]) amount = (CW+2)'(ADD1);
        else if (add_req[0]) amount = (CW+2)'(ADD0);
        add_hit = |add_req;

        // Two guard bits keep credit + largest add from wrapping before the clamp.
        sum  = {2'b00, credit} + amount;
        diff = sum;
        if (dec && (sum != '0)) diff = sum - (CW+2)'(1);

        if (diff > (CW+2)'(MAX_SEC)) result = CW'(MAX_SEC);
        else                         result = diff[CW-1:0];
    end

endmodule

// File: rtl/meter_controller.sv
// Parking meter FSM: prepay in IDLE, free grace window, paid countdown and
// expiry. Every output comes straight from a flop.
module meter_controller
    import parking_pkg::*;
#(
    parameter int MAX_SEC   = MAX_SEC_DEF,
    parameter int GRACE_SEC = GRACE_SEC_DEF,
    parameter int ADD0      = ADD0_DEF,
    parameter int ADD1      = ADD1_DEF,
    parameter int ADD2      = ADD2_DEF,
    parameter int ADD3      = ADD3_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        parked,
    input  logic [3:0]  add_req,
    output logic [11:0] sec_count,
    output logic [1:0]  state,
    output logic        blink,
    output logic        expired_pulse
);

    meter_state_e  state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] grace_q, grace_d;
    logic          blink_q, blink_d;
    logic          pulse_q, pulse_d;

    logic          alu_dec;
    logic          add_hit;
    logic [CW-1:0] alu_credit;

    assign alu_dec = (state_q == ST_PAID) && tick_1hz;

    credit_alu #(
        .MAX_SEC (MAX_SEC),
        .ADD0    (ADD0),
        .ADD1    (ADD1),
        .ADD2    (ADD2),
        .ADD3    (ADD3)
    ) u_credit_alu (
        .credit  (credit_q),
        .dec     (alu_dec),
        .add_req (add_req),
        .add_hit (add_hit),
        .result  (alu_credit)
    );

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        grace_d  = grace_q;
        blink_d  = 1'b0;
        pulse_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                credit_d = alu_credit;
                grace_d  = '0;
                if (parked) begin
                    if (alu_credit != '0) begin
                        state_d = ST_PAID;
                    end else begin
                        state_d = ST_GRACE;
                        grace_d = CW'(GRACE_SEC);
                    end
                end
            end
            ST_GRACE: begin
                if (!parked) begin
                    state_d  = ST_IDLE;
                    credit_d = '0;
                    grace_d  = '0;
                end else if (add_hit) begin
                    state_d  = ST_PAID;
                    credit_d = alu_credit;
                    grace_d  = '0;
                end else begin
                    blink_d = blink_q;
                    if (tick_1hz) begin
                        blink_d = ~blink_q;
                        if (grace_q <= CW'(1)) begin
                            state_d = ST_EXPIRED;
                            grace_d = '0;
                            blink_d = 1'b1;
                            pulse_d = 1'b1;
                        end else begin
                            grace_d = grace_q - CW'(1);
                        end
                    end
                end
            end
            ST_PAID: begin
                if (!parked) begin
                    state_d  = ST_IDLE;
                    credit_d = '0;
                    grace_d  = '0;
                end else begin
                    credit_d = alu_credit;
                    // Zero here means the tick consumed the last second with no add.
                    if (alu_credit == '0) begin
                        state_d = ST_EXPIRED;
                        blink_d = 1'b1;
                        pulse_d = 1'b1;
                    end
                end
            end
            ST_EXPIRED: begin
                if (!parked) begin
                    state_d  = ST_IDLE;
                    credit_d = '0;
                    grace_d  = '0;
                end else if (add_hit) begin
                    state_d  = ST_PAID;
                    credit_d = alu_credit;
                end else begin
                    credit_d = '0;
                    blink_d  = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
                grace_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            grace_q  <= '0;
            blink_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            grace_q  <= grace_d;
            blink_q  <= blink_d;
            pulse_q  <= pulse_d;
        end
    end

    assign sec_count     = credit_q;
    assign state         = state_q;
    assign blink         = blink_q;
    assign expired_pulse = pulse_q;

endmodule

// File: tb/tb_meter_controller.sv
// Self-checking bench for meter_controller: each driven cycle pushes its
// expected outputs, which are popped and compared one edge later.
module tb_meter_controller;
    import parking_pkg::*;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        tick_1hz = 1'b0;
    logic        parked   = 1'b0;
    logic [3:0]  add_req  = 4'b0000;
    logic [11:0] sec_count;
    logic [1:0]  state;
    logic        blink;
    logic        expired_pulse;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    meter_controller dut (
        .clk           (clk),
        .rst           (rst),
        .tick_1hz      (tick_1hz),
        .parked        (parked),
        .add_req       (add_req),
        .sec_count     (sec_count),
        .state         (state),
        .blink         (blink),
        .expired_pulse (expired_pulse)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] e);
        check({tag, "/state"}, {14'd0, state}, {14'd0, e[15:14]});
        check({tag, "/sec"},   {4'd0, sec_count}, {4'd0, e[13:2]});
        check({tag, "/blink"}, {15'd0, blink}, {15'd0, e[1]});
        check({tag, "/pulse"}, {15'd0, expired_pulse}, {15'd0, e[0]});
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
    task automatic step(input string tag, input logic t, input logic p, input logic [3:0] a,
                        input logic [1:0] st, input int sec, input logic b, input logic pl);
        logic [15:0] e;
        tick_1hz = t;
        parked   = p;
        add_req  = a;
        exp_q.push_back({st, 12'(sec), b, pl});
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        add_req  = 4'b0000;
        if (exp_q.size() == 0) begin
            check({tag, "/queue"}, 16'd0, 16'd1);
        end else begin
            e = exp_q.pop_front();
            check_outputs(tag, e);
        end
    endtask

    initial begin
        // Power-on reset values.
        #3;
        check_outputs("por", 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Grace window runs out with no credit.
        step("g_enter", 0, 1, 4'b0000, ST_GRACE, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            repeat ($urandom_range(0, 2))
                step("g_gap", 0, 1, 4'b0000, ST_GRACE, 0, 1'((i - 1) % 2), 0);
            if (i < 10) step("g_tick", 1, 1, 4'b0000, ST_GRACE, 0, 1'(i % 2), 0);
            else        step("g_expire", 1, 1, 4'b0000, ST_EXPIRED, 0, 1, 1);
        end
        step("exp_hold", 0, 1, 4'b0000, ST_EXPIRED, 0, 1, 0);
        step("exp_tick", 1, 1, 4'b0000, ST_EXPIRED, 0, 1, 0);
        step("exp_leave", 0, 0, 4'b0000, ST_IDLE, 0, 0, 0);

        // Prepay in IDLE, then a full 60 s paid countdown.
        step("prepay", 0, 0, 4'b0001, ST_IDLE, 60, 0, 0);
        step("idle_tick", 1, 0, 4'b0000, ST_IDLE, 60, 0, 0);
        step("paid_enter", 0, 1, 4'b0000, ST_PAID, 60, 0, 0);
        for (int i = 1; i <= 60; i++) begin
            if (i < 60) step("paid_tick", 1, 1, 4'b0000, ST_PAID, 60 - i, 0, 0);
            else        step("paid_expire", 1, 1, 4'b0000, ST_EXPIRED, 0, 1, 1);
        end
        step("pulse_once", 0, 1, 4'b0000, ST_EXPIRED, 0, 1, 0);

        // Climb to 3500 s, then exercise the saturation ceiling.
        step("exp_add", 0, 1, 4'b1000, ST_PAID, 600, 0, 0);
        for (int i = 2; i <= 5; i++) step("add600", 0, 1, 4'b1000, ST_PAID, 600 * i, 0, 0);
        step("add300", 0, 1, 4'b0100, ST_PAID, 3300, 0, 0);
        step("add120a", 0, 1, 4'b0010, ST_PAID, 3420, 0, 0);
        step("add120b", 0, 1, 4'b0010, ST_PAID, 3540, 0, 0);
        for (int i = 1; i <= 40; i++) step("down", 1, 1, 4'b0000, ST_PAID, 3540 - i, 0, 0);
        step("sat_multi", 0, 1, 4'b1001, ST_PAID, 3599, 0, 0);
        step("sat_tick", 1, 1, 4'b0000, ST_PAID, 3598, 0, 0);
        step("sat_add", 0, 1, 4'b0001, ST_PAID, 3599, 0, 0);
        step("sat_tick_add", 1, 1, 4'b0001, ST_PAID, 3599, 0, 0);
        step("sat_tick2", 1, 1, 4'b0000, ST_PAID, 3598, 0, 0);

        // Leftover credit forfeited; grace add races a tick; last-second rescue.
        step("forfeit", 0, 0, 4'b0000, ST_IDLE, 0, 0, 0);
        step("g_enter2", 0, 1, 4'b0000, ST_GRACE, 0, 0, 0);
        step("g_add_tick", 1, 1, 4'b0001, ST_PAID, 60, 0, 0);
        for (int i = 1; i <= 59; i++) step("to_one", 1, 1, 4'b0000, ST_PAID, 60 - i, 0, 0);
        step("rescue", 1, 1, 4'b0010, ST_PAID, 120, 0, 0);
        step("rescue_hold", 0, 1, 4'b0000, ST_PAID, 120, 0, 0);

        // Leave while tick and add coincide.
        step("leave_idle", 0, 0, 4'b0000, ST_IDLE, 0, 0, 0);
        step("prio_prepay", 0, 0, 4'b0110, ST_IDLE, 300, 0, 0);
        step("paid300", 0, 1, 4'b0000, ST_PAID, 300, 0, 0);
        step("leave_race", 1, 0, 4'b1000, ST_IDLE, 0, 0, 0);

        // Asynchronous reset mid-countdown, then re-evaluation of parked.
        step("prepay300", 0, 0, 4'b0100, ST_IDLE, 300, 0, 0);
        step("paid300b", 0, 1, 4'b0000, ST_PAID, 300, 0, 0);
        step("paid299", 1, 1, 4'b0000, ST_PAID, 299, 0, 0);
        rst = 1'b1;
        #2;
        check_outputs("async_rst", 16'd0);
        @(posedge clk);
        #1;
        check_outputs("rst_held", 16'd0);
        rst = 1'b0;
        step("post_rst", 0, 1, 4'b0000, ST_GRACE, 0, 0, 0);
        step("post_tick1", 1, 1, 4'b0000, ST_GRACE, 0, 1, 0);
        step("post_tick2", 1, 1, 4'b0000, ST_GRACE, 0, 0, 0);
        step("post_leave", 0, 0, 4'b0000, ST_IDLE, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
